vga_fb_scheduler: RTL and testbench
===================================

Name: vga_fb_scheduler

Overview:
- Schedules one single-port synchronous frame-buffer RAM between two users: VGA scan-out reads and matrix-multiply result writes.
- Display reads own the port inside the visible window, timed from the horizontal/vertical pixel counters. Result writes are queued in a small FIFO and drained on any cycle the display does not need the port.
- Double-buffered: the writer fills the back buffer, and a requested buffer swap is applied at the start of vertical blanking.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- XW, 10, x address width
- YW, 9, y address width
- DW, 8, pixel data width
- FIFO_DEPTH, 4, write-queue entries (power of 2, ≥2)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  async active-low reset
- h_count  in  11  horizontal pixel counter
- v_count  in  10  vertical line counter
- wr_valid  in  1  writer request
- wr_ready  out  1  writer may push this cycle
- wr_x  in  XW  write pixel column
- wr_y  in  YW  write pixel row
- wr_data  in  DW  write pixel value
- swap_req  in  1  one-cycle pulse: back buffer complete
- swap_done  out  1  one-cycle pulse: swap applied
- front_sel  out  1  buffer currently displayed
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  1+YW+XW  {buffer, y, x}
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid 1 cycle after a read
- pix_data  out  DW  display pixel
- pix_valid  out  1  pix_data is a visible pixel

Behaviour:
- Reset (async, reset_n low): all outputs 0, FIFO empty, swap_pending=0, front_sel=0.
- Display window: disp = (h_count < H_VISIBLE) && (v_count < V_VISIBLE).
- Port grant each cycle, combinational decode registered onto the mem_* outputs, one grant per cycle:
  - READ if disp: mem_en=1, mem_we=0, mem_addr={front_sel, v_count[YW-1:0], h_count[XW-1:0]}.
  - else WRITE if FIFO non-empty: pop the head, mem_en=1, mem_we=1, mem_addr={~front_sel, y, x}, mem_wdata=data.
  - else IDLE: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last value.
- Read pipeline:
  - A read is registered at cycle t+1 (t = counter cycle), and RAM data returns at t+2.
  - pix_valid and pix_data are registered at t+3, so pixel latency is 3 clocks from h_count.
  - pix_valid is a 3-stage delay of disp. pix_data is forced to 0 when pix_valid=0.
  - Downstream delays hsync/vsync by 3 to match.
- Write FIFO:
  - Push when wr_valid && wr_ready.
  - wr_ready = !full && !swap_pending.
  - Push and pop in the same cycle leave the count unchanged. A push into an empty FIFO cannot pop in the same cycle; the entry drains the following cycle at the earliest.
  - wr_valid while wr_ready=0 is ignored; the writer must hold its request.
- Swap control:
  - A swap_req pulse sets swap_pending. While pending, writer pushes are blocked.
  - The swap executes on the first cycle with v_count ≥ V_VISIBLE, swap_pending=1, FIFO empty, and no write issued that cycle. It toggles front_sel, pulses swap_done for 1 cycle, and clears swap_pending.
  - If vblank ends before the FIFO empties, the swap stays pending into the next frame's vblank. front_sel never changes during visible lines.
  - A swap_req while already pending is absorbed; there is no double toggle.
  - A swap_req in the same cycle a swap executes leaves swap_pending=1 for the next frame.
- Counter wrap (h_count overflowing past H_VISIBLE, new line/frame): no special handling; disp is evaluated every cycle.
- Reset mid-operation: FIFO contents are discarded, any pending swap is lost, and front_sel returns to 0.

Test Plan:
- Reset, then run counters at line 10 with h_count 0..639 -> mem_addr={0,10,h}, mem_we=0; pix_valid rises 3 clocks after h_count=0 and pix_data equals the preloaded RAM[0,10,h].
- Push 4 writes at h_count=100 (visible) -> wr_ready=0 after the 4th; all 4 writes issue consecutively from h_count=640 with mem_addr buffer bit=1.
- Push 1 write at h_count=700 (blanking) with an empty FIFO -> mem_we=1 exactly 2 clocks later at {1,y,x}; no read cycles are disturbed.
- swap_req at v_count=200 with FIFO empty -> wr_ready=0 until the swap; at v_count=480, h_count=0 front_sel goes 1 and swap_done pulses 1 cycle; line 0 of the next frame reads with buffer bit=1.
- Hold 3 entries in the FIFO, pulse swap_req twice, and force writes to be blocked through vblank -> the swap is deferred to the next vblank and front_sel toggles exactly once.
- Assert reset_n low mid-line with 2 entries queued -> all outputs 0 immediately, the FIFO is empty after release, and no stale write appears.

Source files
------------

// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - frame-buffer port scheduler for VGA scan-out and result writes
module vga_fb_scheduler #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [10:0]       h_count,
  input  logic [9:0]        v_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [DW-1:0]     wr_data,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [YW+XW:0]    mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [DW-1:0]     pix_data,
  output logic              pix_valid
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [10:0] H_LIM    = 11'(H_VISIBLE);
  localparam logic [9:0]  V_LIM    = 10'(V_VISIBLE);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [XW-1:0] fx_q [FIFO_DEPTH];
  logic [YW-1:0] fy_q [FIFO_DEPTH];
  logic [DW-1:0] fd_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          swap_pending_q, swap_pending_d;
  logic          front_sel_q, front_sel_d, swap_done_q;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [YW+XW:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          disp_q1, disp_q2, pix_valid_q;
  logic [DW-1:0] pix_data_q;
  logic          disp, vblank, empty, full, push, pop, swap_exec;

  always_comb begin
    disp      = (h_count < H_LIM) && (v_count < V_LIM);
    vblank    = (v_count >= V_LIM);
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    wr_ready  = reset_n && !full && !swap_pending_q;
    push      = wr_valid && wr_ready;
    // Display reads always win; the queue only drains on cycles outside the window.
    pop       = !disp && !empty;
    swap_exec = vblank && swap_pending_q && empty && !pop;

    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp) begin
      mem_en_d   = 1'b1;
      mem_addr_d = {front_sel_q, v_count[YW-1:0], h_count[XW-1:0]};
    end else if (pop) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = {~front_sel_q, fy_q[rd_ptr_q], fx_q[rd_ptr_q]};
      mem_wdata_d = fd_q[rd_ptr_q];
    end

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A request arriving on the execute cycle belongs to the next frame.
    swap_pending_d = swap_exec ? swap_req : (swap_pending_q | swap_req);
    front_sel_d    = front_sel_q ^ swap_exec;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fx_q[wr_ptr_q] <= wr_x;
      fy_q[wr_ptr_q] <= wr_y;
      fd_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      swap_pending_q <= 1'b0;
      front_sel_q    <= 1'b0;
      swap_done_q    <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      disp_q1        <= 1'b0;
      disp_q2        <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      swap_pending_q <= swap_pending_d;
      front_sel_q    <= front_sel_d;
      swap_done_q    <= swap_exec;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      disp_q1        <= disp;
      disp_q2        <= disp_q1;
      pix_valid_q    <= disp_q2;
      pix_data_q     <= disp_q2 ? mem_rdata : '0;
    end
  end

  assign swap_done = swap_done_q;
  assign front_sel = front_sel_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb/tb_vga_fb_scheduler.sv - randomized self-checking bench for vga_fb_scheduler
module tb_vga_fb_scheduler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] h_count = '0;
  logic [9:0]  v_count = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [9:0]  wr_x = '0;
  logic [8:0]  wr_y = '0;
  logic [7:0]  wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_done, front_sel, mem_en, mem_we;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  pix_data;
  logic        pix_valid;

  always #5 clk = ~clk;

  vga_fb_scheduler dut (
    .clk(clk), .reset_n(reset_n), .h_count(h_count), .v_count(v_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .swap_req(swap_req), .swap_done(swap_done), .front_sel(front_sel),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
  );

  // Frame-buffer RAM: unwritten locations hold a fixed address-derived pattern.
  logic [7:0] ram [logic [19:0]];

  function automatic logic [7:0] pattern(input logic [19:0] a);
    logic [19:0] t;
    t = a * 20'd7 + (a >> 9);
    return t[7:0];
  endfunction

  function automatic logic [7:0] rd(input logic [19:0] a);
    if (ram.exists(a)) return ram[a];
    return pattern(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else        mem_rdata <= rd(mem_addr);
    end
  end

  // Reference model: pending writes as a queue, expected bus/pixel values per cycle.
  typedef struct packed { logic [8:0] y; logic [9:0] x; logic [7:0] d; } wr_t;
  wr_t         mq[$];
  bit          m_front, m_pending;
  logic        e_en, e_we, e_ready, e_done, e_pv;
  logic [19:0] e_addr;
  logic [7:0]  e_wdata, e_pd;
  bit          pv0, pv1;
  logic [19:0] pa0, pa1;
  int          n_tests = 0, n_fail = 0;

  task automatic model_reset();
    mq.delete();
    m_front = 0; m_pending = 0;
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_done = 0; e_pv = 0; e_pd = '0;
    e_ready = 1; pv0 = 0; pv1 = 0; pa0 = '0; pa1 = '0;
  endtask

  task automatic tick();
    bit disp, popped, swap, push;
    wr_t w;
    disp   = (h_count < 640) && (v_count < 480);
    push   = wr_valid && e_ready;
    popped = 0;
    e_pv = pv1;
    e_pd = pv1 ? rd(pa1) : 8'h00;
    pv1 = pv0; pa1 = pa0;
    pv0 = disp; pa0 = {m_front, v_count[8:0], h_count[9:0]};
    if (disp) begin
      e_en = 1; e_we = 0; e_addr = {m_front, v_count[8:0], h_count[9:0]};
    end else if (mq.size() > 0) begin
      w = mq.pop_front();
      e_en = 1; e_we = 1; e_addr = {~m_front, w.y, w.x}; e_wdata = w.d; popped = 1;
    end else begin
      e_en = 0; e_we = 0;
    end
    swap = (v_count >= 480) && m_pending && (mq.size() == 0) && !popped;
    m_pending = swap ? swap_req : (m_pending | swap_req);
    if (swap) m_front = ~m_front;
    e_done = swap;
    if (push) mq.push_back({wr_y, wr_x, wr_data});
    e_ready = (mq.size() < 4) && !m_pending;
    @(posedge clk); #1;
  endtask

  task automatic new_wr();
    wr_x = 10'($urandom_range(0, 639));
    wr_y = 9'($urandom_range(0, 479));
    wr_data = 8'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({wr_ready, swap_done, front_sel, mem_en, mem_we, mem_addr, mem_wdata, pix_data, pix_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", {wr_ready, swap_done, front_sel, mem_en, mem_we, mem_addr, mem_wdata, pix_data, pix_valid});
    end
    reset_n = 1;
    model_reset();
    #1;
    n_tests++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
  endtask

  task automatic test_scan_line();
    int first_pv = -1;
    v_count = 10;
    for (int i = 0; i < 646; i++) begin
      h_count = 11'(i);
      tick();
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wdata}) begin
        n_fail++; $display("FAIL scan_mem i=%0d got %b%b %h %h exp %b%b %h %h", i, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      n_tests++;
      if ({pix_valid, pix_data} !== {e_pv, e_pd}) begin
        n_fail++; $display("FAIL scan_pix i=%0d got %b %h exp %b %h", i, pix_valid, pix_data, e_pv, e_pd);
      end
      if (pix_valid === 1'b1 && first_pv < 0) first_pv = i;
    end
    n_tests++;
    if (first_pv != 2) begin n_fail++; $display("FAIL scan_latency got %0d exp 2", first_pv); end
  endtask

  task automatic test_fifo_fill();
    bit acc;
    int nw = 0, first = -1;
    v_count = 20;
    new_wr();
    for (int i = 0; i < 560; i++) begin
      h_count = 11'(100 + i);
      wr_valid = (i < 6);
      acc = wr_valid && e_ready;
      tick();
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wdata}) begin
        n_fail++; $display("FAIL fill_mem i=%0d got %b%b %h %h exp %b%b %h %h", i, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      n_tests++;
      if ({wr_ready, front_sel, swap_done} !== {e_ready, m_front, e_done}) begin
        n_fail++; $display("FAIL fill_ctl i=%0d got %b%b%b exp %b%b%b", i, wr_ready, front_sel, swap_done, e_ready, m_front, e_done);
      end
      if (i == 3) begin
        n_tests++;
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got %b exp 0", wr_ready); end
      end
      if (mem_we === 1'b1) begin
        nw++;
        if (first < 0) first = i;
        n_tests++;
        if (mem_addr[19] !== 1'b1) begin n_fail++; $display("FAIL fill_buf got %b exp 1", mem_addr[19]); end
      end
      if (acc) new_wr();
    end
    wr_valid = 0;
    n_tests++;
    if (nw != 4 || first != 540) begin n_fail++; $display("FAIL fill_drain got %0d@%0d exp 4@540", nw, first); end
  endtask

  task automatic test_blank_write();
    int we_at = -1, nw = 0;
    v_count = 30;
    new_wr();
    for (int i = 0; i < 6; i++) begin
      h_count = 11'(700 + i);
      wr_valid = (i == 0);
      tick();
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wdata}) begin
        n_fail++; $display("FAIL blank_mem i=%0d got %b%b %h %h exp %b%b %h %h", i, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      if (mem_we === 1'b1) begin nw++; we_at = i; end
    end
    n_tests++;
    if (nw != 1 || we_at != 1) begin n_fail++; $display("FAIL blank_timing got %0d@%0d exp 1@1", nw, we_at); end
  endtask

  task automatic test_swap();
    for (int i = 0; i < 24; i++) begin
      if (i < 10)      begin v_count = 200; h_count = 11'(300 + i); end
      else if (i < 14) begin v_count = 480; h_count = 11'(i - 10); end
      else             begin v_count = 0;   h_count = 11'(i - 14); end
      swap_req = (i == 0);
      wr_valid = (i >= 2 && i < 10);
      if (i == 2) new_wr();
      tick();
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wdata}) begin
        n_fail++; $display("FAIL swap_mem i=%0d got %b%b %h %h exp %b%b %h %h", i, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      n_tests++;
      if ({wr_ready, front_sel, swap_done} !== {e_ready, m_front, e_done}) begin
        n_fail++; $display("FAIL swap_ctl i=%0d got %b%b%b exp %b%b%b", i, wr_ready, front_sel, swap_done, e_ready, m_front, e_done);
      end
      if (i == 10) begin
        n_tests++;
        if ({front_sel, swap_done} !== 2'b11) begin n_fail++; $display("FAIL swap_exec got %b%b exp 11", front_sel, swap_done); end
      end
      if (i >= 15) begin
        n_tests++;
        if (mem_addr[19] !== 1'b1) begin n_fail++; $display("FAIL swap_readbuf i=%0d got %b exp 1", i, mem_addr[19]); end
      end
    end
    swap_req = 0;
    wr_valid = 0;
  endtask

  task automatic test_deferred_swap();
    int n_done = 0, done_at = -1;
    bit start_front;
    start_front = m_front;
    new_wr();
    for (int i = 0; i < 38; i++) begin
      if (i < 10)      begin v_count = 100; h_count = 11'(200 + i); end
      else if (i < 12) begin v_count = 480; h_count = 11'(630 + i); end
      else if (i < 32) begin v_count = 0;   h_count = 11'(i - 12); end
      else             begin v_count = 480; h_count = 11'(i - 32); end
      wr_valid = (i < 3);
      swap_req = (i == 4 || i == 6);
      tick();
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wdata}) begin
        n_fail++; $display("FAIL defer_mem i=%0d got %b%b %h %h exp %b%b %h %h", i, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      n_tests++;
      if ({wr_ready, front_sel, swap_done} !== {e_ready, m_front, e_done}) begin
        n_fail++; $display("FAIL defer_ctl i=%0d got %b%b%b exp %b%b%b", i, wr_ready, front_sel, swap_done, e_ready, m_front, e_done);
      end
      if (swap_done === 1'b1) begin n_done++; done_at = i; end
      if (i < 3) new_wr();
    end
    swap_req = 0;
    wr_valid = 0;
    n_tests++;
    if (n_done != 1 || done_at != 33 || front_sel !== ~start_front) begin
      n_fail++; $display("FAIL defer_once got %0d@%0d front %b exp 1@33 front %b", n_done, done_at, front_sel, ~start_front);
    end
  endtask

  task automatic test_reset_mid();
    int nw = 0;
    v_count = 50;
    new_wr();
    for (int i = 0; i < 4; i++) begin
      h_count = 11'(10 + i);
      wr_valid = (i < 2);
      tick();
      new_wr();
    end
    wr_valid = 0;
    swap_req = 1;
    tick();
    swap_req = 0;
    reset_n = 0;
    #2;
    n_tests++;
    if ({wr_ready, swap_done, front_sel, mem_en, mem_we, mem_addr, mem_wdata, pix_data, pix_valid} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %h exp 0", {wr_ready, swap_done, front_sel, mem_en, mem_we, mem_addr, mem_wdata, pix_data, pix_valid});
    end
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      v_count = 480;
      h_count = 11'(i);
      tick();
      n_tests++;
      if ({mem_en, mem_we, wr_ready, front_sel, swap_done} !== {e_en, e_we, e_ready, m_front, e_done}) begin
        n_fail++; $display("FAIL midreset_after i=%0d got %b%b%b%b%b exp %b%b%b%b%b", i, mem_en, mem_we, wr_ready, front_sel, swap_done, e_en, e_we, e_ready, m_front, e_done);
      end
      if (mem_we === 1'b1) nw++;
    end
    n_tests++;
    if (nw != 0) begin n_fail++; $display("FAIL midreset_stale got %0d writes exp 0", nw); end
  endtask

  task automatic test_random();
    bit acc;
    new_wr();
    for (int i = 0; i < 3000; i++) begin
      h_count = 11'($urandom_range(0, 799));
      v_count = 10'($urandom_range(0, 524));
      swap_req = ($urandom_range(0, 39) == 0);
      if (!wr_valid) wr_valid = $urandom_range(0, 1) == 1;
      acc = wr_valid && e_ready;
      tick();
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wdata}) begin
        n_fail++; $display("FAIL rand_mem i=%0d got %b%b %h %h exp %b%b %h %h", i, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      n_tests++;
      if ({pix_valid, pix_data} !== {e_pv, e_pd}) begin
        n_fail++; $display("FAIL rand_pix i=%0d got %b %h exp %b %h", i, pix_valid, pix_data, e_pv, e_pd);
      end
      n_tests++;
      if ({wr_ready, front_sel, swap_done} !== {e_ready, m_front, e_done}) begin
        n_fail++; $display("FAIL rand_ctl i=%0d got %b%b%b exp %b%b%b", i, wr_ready, front_sel, swap_done, e_ready, m_front, e_done);
      end
      if (acc) begin
        new_wr();
        wr_valid = 0;
      end
    end
    wr_valid = 0;
    swap_req = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_line();
    test_fifo_fill();
    test_blank_write();
    test_swap();
    test_deferred_swap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
